// File: rtl/shift_defs.sv
// Shared definitions for the PISO serializer: bit-order selectors and a
// constant-evaluable ceil(log2) used for parameter sanity checks.
package shift_defs;

  localparam bit SHIFT_LSB_FIRST = 1'b0;
  localparam bit SHIFT_MSB_FIRST = 1'b1;

  // Smallest n with 2**n >= value; evaluated at elaboration time.
  function automatic int shift_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Producer-side handshake and line-driver-side serial signals of the serializer.
interface piso_serializer_if #(
  parameter int WIDTH  = 32,
  parameter int CWIDTH = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [CWIDTH-1:0] in_len;
  logic              enable;
  logic              sout;
  logic              sout_valid;
  logic              last;
  logic              busy;

  modport master (
    output in_valid, in_data, in_len, enable,
    input  in_ready, sout, sout_valid, last, busy
  );

  modport slave (
    input  in_valid, in_data, in_len, enable,
    output in_ready, sout, sout_valid, last, busy
  );
endinterface

// File: rtl/piso_lane.sv
// Active word register of the serializer: holds the word being shifted out,
// walks its bit index on each enable and flags the final bit.
module piso_lane
  import shift_defs::*;
#(
  parameter int WIDTH     = 32,
  parameter int CWIDTH    = 5,
  parameter bit MSB_FIRST = SHIFT_LSB_FIRST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_data_i,
  input  logic [CWIDTH-1:0] load_len_i,
  input  logic              enable_i,
  output logic              full_o,
  output logic              sout_o,
  output logic              last_o
);

  logic [WIDTH-1:0]  data_q, data_d;
  logic [CWIDTH-1:0] len_q, len_d;
  logic [CWIDTH-1:0] idx_q, idx_d;
  logic              full_q, full_d;
  logic [CWIDTH-1:0] sel;
  logic [WIDTH-1:0]  shifted;

  assign full_o = full_q;
  assign last_o = full_q && (idx_q == len_q);

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (load_i) begin
      data_d = load_data_i;
      len_d  = load_len_i;
      idx_d  = '0;
      full_d = 1'b1;
    end else if (enable_i && full_q) begin
      if (last_o) full_d = 1'b0;
      else        idx_d  = idx_q + CWIDTH'(1);
    end
  end

  // A shift rather than a variable part-select keeps the index width free of
  // the word width; len is clamped below WIDTH so sel always lands in range.
  always_comb begin
    if (MSB_FIRST == SHIFT_MSB_FIRST) sel = len_q - idx_q;
    else                              sel = idx_q;
    shifted = data_q >> sel;
    sout_o  = full_q && shifted[0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  // NOTE: the data register is a plain flop, not a memory, so it is reset to a
  // known zero along with the control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready input, a one-word hold
// buffer for gapless streaming, per-word length and selectable bit order.
module piso_serializer
  import shift_defs::*;
#(
  parameter int WIDTH     = 32,
  parameter int CWIDTH    = 5,
  parameter bit MSB_FIRST = SHIFT_LSB_FIRST
) (
  input logic               clk,
  input logic               reset,
  piso_serializer_if.slave  bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("piso_serializer: WIDTH must be at least 2");
  end
  if (shift_clog2(WIDTH) > CWIDTH) begin : g_bad_cwidth
    $error("piso_serializer: CWIDTH too narrow to index WIDTH bits");
  end

  localparam logic [CWIDTH-1:0] MAX_LEN = CWIDTH'(WIDTH - 1);

  logic [WIDTH-1:0]  hold_data_q, hold_data_d;
  logic [CWIDTH-1:0] hold_len_q, hold_len_d;
  logic              hold_full_q, hold_full_d;

  logic              lane_full, lane_last, lane_sout;
  logic              load;
  logic [WIDTH-1:0]  load_data;
  logic [CWIDTH-1:0] load_len;
  logic [CWIDTH-1:0] in_len_eff;
  logic              accept, word_done;

  assign in_len_eff   = (bus.in_len > MAX_LEN) ? MAX_LEN : bus.in_len;
  assign bus.in_ready = !reset && !hold_full_q;
  assign accept       = bus.in_valid && bus.in_ready;
  assign word_done    = bus.enable && lane_last;

  // Accept and promotion are exclusive: accepting requires an empty hold.
  always_comb begin
    load        = 1'b0;
    load_data   = bus.in_data;
    load_len    = in_len_eff;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    hold_full_d = hold_full_q;
    if (accept && (!lane_full || word_done)) begin
      load = 1'b1;
    end else if (accept) begin
      hold_data_d = bus.in_data;
      hold_len_d  = in_len_eff;
      hold_full_d = 1'b1;
    end else if (word_done && hold_full_q) begin
      load        = 1'b1;
      load_data   = hold_data_q;
      load_len    = hold_len_q;
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data_q <= '0;
      hold_len_q  <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
      hold_full_q <= hold_full_d;
    end
  end

  piso_lane #(
    .WIDTH     (WIDTH),
    .CWIDTH    (CWIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_lane (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .load_data_i (load_data),
    .load_len_i  (load_len),
    .enable_i    (bus.enable),
    .full_o      (lane_full),
    .sout_o      (lane_sout),
    .last_o      (lane_last)
  );

  assign bus.sout       = lane_sout;
  assign bus.sout_valid = lane_full;
  assign bus.last       = lane_last;
  assign bus.busy       = lane_full || hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed, table-driven bench for piso_serializer: one LSB-first and one
// MSB-first instance (WIDTH=8, CWIDTH=5) sharing clock and reset.
module tb_piso_serializer;

  logic clk;
  logic rst;

  piso_serializer_if #(.WIDTH(8), .CWIDTH(5)) bus_l ();
  piso_serializer_if #(.WIDTH(8), .CWIDTH(5)) bus_m ();

  piso_serializer #(.WIDTH(8), .CWIDTH(5), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_l)
  );

  piso_serializer #(.WIDTH(8), .CWIDTH(5), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp packs {in_ready, sout, sout_valid, last, busy} seen before the edge.
  typedef struct {
    logic       in_valid;
    logic [7:0] data;
    logic [4:0] len;
    logic       enable;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void add(input logic v, input logic [7:0] d, input logic [4:0] l,
                              input logic e, input logic rdy, input logic so,
                              input logic sv, input logic la, input logic bz);
    vec_t r;
    r.in_valid = v;
    r.data     = d;
    r.len      = l;
    r.enable   = e;
    r.exp      = {rdy, so, sv, la, bz};
    tbl.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h {rdy,sout,vld,last,busy}", name, act, exp);
    end
  endtask

  task automatic drive(input bit msb, input logic v, input logic [7:0] d,
                       input logic [4:0] l, input logic e);
    if (msb) begin
      bus_m.in_valid = v; bus_m.in_data = d; bus_m.in_len = l; bus_m.enable = e;
      bus_l.in_valid = 1'b0; bus_l.enable = 1'b0;
    end else begin
      bus_l.in_valid = v; bus_l.in_data = d; bus_l.in_len = l; bus_l.enable = e;
      bus_m.in_valid = 1'b0; bus_m.enable = 1'b0;
    end
  endtask

  function automatic logic [4:0] observe(input bit msb);
    if (msb) return {bus_m.in_ready, bus_m.sout, bus_m.sout_valid, bus_m.last, bus_m.busy};
    return {bus_l.in_ready, bus_l.sout, bus_l.sout_valid, bus_l.last, bus_l.busy};
  endfunction

  task automatic run_table(input bit msb, input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(msb, tbl[i].in_valid, tbl[i].data, tbl[i].len, tbl[i].enable);
      #1;
      check($sformatf("%s[%0d]", tag, i), 32'(observe(msb)), 32'(tbl[i].exp));
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w;
    logic [7:0] w1, w2, w3;
    logic [7:0] words [3];
    int k, b;

    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 5'd0, 1'b0);
    #3;
    check("reset_lsb", 32'(observe(1'b0)), 32'h0);
    check("reset_msb", 32'(observe(1'b1)), 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_lsb", 32'(observe(1'b0)), 32'b10000);
    check("release_msb", 32'(observe(1'b1)), 32'b10000);
    @(posedge clk);
    #1;

    // LSB-first 8'hA5, full length: 1,0,1,0,0,1,0,1.
    w = 8'hA5;
    add(1, w, 5'd7, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 8'h00, 5'd0, 1, 1, w[i], 1, i == 7, 1);
    add(0, 8'h00, 5'd0, 1, 1, 0, 0, 0, 0);
    run_table(1'b0, "lsb_a5");

    // MSB-first 8'hA5, len 3: bits 3..0 = 0,1,0,1.
    add(1, 8'hA5, 5'd3, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 5'd0, 1, 1, 0, 1, 0, 1);
    add(0, 8'h00, 5'd0, 1, 1, 1, 1, 0, 1);
    add(0, 8'h00, 5'd0, 1, 1, 0, 1, 0, 1);
    add(0, 8'h00, 5'd0, 1, 1, 1, 1, 1, 1);
    add(0, 8'h00, 5'd0, 1, 1, 0, 0, 0, 0);
    run_table(1'b1, "msb_a5");

    // Gapless streaming of FF, 00, F0: 24 valid bits from cycle 1 to 24.
    words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'hF0;
    for (int c = 0; c < 26; c++) begin
      logic v, rdy, sv, so, la;
      logic [7:0] d;
      v   = (c <= 9);
      d   = (c == 0) ? 8'hFF : (c == 1) ? 8'h00 : 8'hF0;
      rdy = (c <= 1) || (c == 9) || (c >= 17);
      sv  = (c >= 1) && (c <= 24);
      k   = sv ? (c - 1) / 8 : 0;
      b   = sv ? (c - 1) % 8 : 0;
      w   = words[k];
      so  = sv && w[b];
      la  = sv && (b == 7);
      add(v, d, 5'd7, 1, rdy, so, sv, la, sv);
    end
    run_table(1'b0, "stream");

    // Backpressure: second word parks in hold, third waits for promotion.
    w1 = 8'h3C; w2 = 8'hC3; w3 = 8'h81;
    add(1, w1, 5'd7, 0, 1, 0, 0, 0, 0);
    add(1, w2, 5'd7, 0, 1, w1[0], 1, 0, 1);
    add(1, w3, 5'd7, 0, 0, w1[0], 1, 0, 1);
    add(1, w3, 5'd7, 0, 0, w1[0], 1, 0, 1);
    for (int i = 0; i < 8; i++) add(1, w3, 5'd7, 1, 0, w1[i], 1, i == 7, 1);
    add(1, w3, 5'd7, 1, 1, w2[0], 1, 0, 1);
    for (int i = 1; i < 8; i++) add(0, 8'h00, 5'd0, 1, 0, w2[i], 1, i == 7, 1);
    for (int i = 0; i < 8; i++) add(0, 8'h00, 5'd0, 1, 1, w3[i], 1, i == 7, 1);
    add(0, 8'h00, 5'd0, 1, 1, 0, 0, 0, 0);
    run_table(1'b0, "backpr");

    // Length clamp (31 -> 7) then a single-bit word.
    w = 8'h96;
    add(1, w, 5'd31, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 8'h00, 5'd0, 1, 1, w[i], 1, i == 7, 1);
    add(1, 8'h01, 5'd0, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 5'd0, 1, 1, 1, 1, 1, 1);
    add(0, 8'h00, 5'd0, 1, 1, 0, 0, 0, 0);
    run_table(1'b0, "clamp");

    // Async reset at bit 3 of a word with the hold buffer full.
    w = 8'hA5;
    add(1, w, 5'd7, 1, 1, 0, 0, 0, 0);
    add(1, 8'h5A, 5'd7, 1, 1, w[0], 1, 0, 1);
    add(0, 8'h00, 5'd0, 1, 0, w[1], 1, 0, 1);
    add(0, 8'h00, 5'd0, 1, 0, w[2], 1, 0, 1);
    run_table(1'b0, "pre_rst");
    drive(1'b0, 1'b0, 8'h00, 5'd0, 1'b1);
    #1;
    check("rst_bit3", 32'(observe(1'b0)), 32'({1'b0, w[3], 1'b1, 1'b0, 1'b1}));
    rst = 1'b1;
    #1;
    check("rst_async", 32'(observe(1'b0)), 32'h0);
    @(posedge clk);
    #1;
    check("rst_held", 32'(observe(1'b0)), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release", 32'(observe(1'b0)), 32'b10000);
    w = 8'h0E;
    add(1, w, 5'd3, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 8'h00, 5'd0, 1, 1, w[i], 1, i == 3, 1);
    add(0, 8'h00, 5'd0, 1, 1, 0, 0, 0, 0);
    run_table(1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer; successor to the fixed 32-bit shifter.
- Adds a valid/ready input handshake and a one-word holding buffer, so back-to-back words stream with no idle bit between them.
- Adds a per-word bit length and a compile-time bit order (LSB- or MSB-first).
- Sits between a word-wide producer (register file / FIFO) and a bit-serial line driver that strobes `enable` once per bit.

Parameters:
- WIDTH, 32, word width in bits (>= 2).
- CWIDTH, 5, bit-index/length width; must satisfy 2**CWIDTH >= WIDTH.
- MSB_FIRST, 0, bit order. 0 = bit 0 first, ascending. 1 = bit len first, descending.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  serializer can accept a word this cycle.
- in_data  input  WIDTH  parallel word.
- in_len  input  CWIDTH  number of bits to send minus 1; sampled with in_data.
- enable  input  1  shift strobe: consume the current bit.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a valid bit.
- last  output  1  current bit is the final bit of its word.
- busy  output  1  active word or held word present.

Behaviour:
- Storage:
  - Active register: data, len, index, full flag.
  - Hold register: data, len, full flag.
- Reset (async, any time, including mid-word): both full flags = 0, index = 0, data = 0.
  - Outputs during/after reset: sout = 0, sout_valid = 0, last = 0, busy = 0.
  - in_ready = !reset && !hold_full, so it is 0 while reset is high and 1 on the first cycle after release.
  - A word in flight is discarded without notice.
- Length clamp: effective len = min(in_len, WIDTH-1), applied at capture.
- Accept rule: a transfer occurs on a rising edge with in_valid && in_ready.
  - in_ready = !hold_full; it never depends on in_valid.
- Routing of an accepted word:
  - If the active register is empty, or it completes this edge (enable && last), the word loads directly into active with index = 0.
  - Otherwise the word goes into hold.
- Promotion: on an edge where enable && last and hold_full, hold moves into active (index = 0) and hold_full clears.
  - in_ready returns to 1 in the next cycle.
  - No accept can coincide with promotion, because in_ready = 0 while hold is full.
- Latency: word accepted into an empty block at edge t gives sout_valid = 1 and its first bit on sout from t+1 (registered, one cycle).
- Streaming: continuous enable with a steady producer yields one bit per enable and zero gap cycles between words.
- Bit selection (combinational from active):
  - MSB_FIRST = 0: sout = data[index].
  - MSB_FIRST = 1: sout = data[len - index].
  - sout = 0 when active is empty.
- Flags:
  - last = active_full && (index == len).
  - busy = active_full || hold_full.
- Shift: enable && active_full && !last increments index.
  - enable && last ends the word: active_full clears unless reloaded by promotion or direct accept.
  - enable while active is empty is ignored.
  - index never wraps past len.
- Length edge case: len = 0 gives a single-bit word; last = 1 on its only bit.
- Producer contract: in_data/in_len must stay stable while in_valid && !in_ready. The block does not check this.

Decomposition:
- Package/include file `shift_defs`:
  - bit-order constants (SHIFT_LSB_FIRST = 0, SHIFT_MSB_FIRST = 1);
  - a clog2 helper function used to check CWIDTH.
- Sub-module `piso_lane`: active data/len/index register with bit-select and last logic, parametrised by WIDTH, CWIDTH, MSB_FIRST.
- Top module contains: the hold register, the handshake, and the routing/promotion control.

Test Plan:
- Reset: WIDTH = 8, LSB-first. Accept 8'hA5 with len = 7, enable every cycle → sout sequence 1,0,1,0,0,1,0,1; last high only on the 8th bit; sout_valid drops the cycle after.
- Bit order: MSB_FIRST = 1, 8'hA5, len = 3 → sout 0,1,0,1 (bits 3..0); last on the 4th bit; busy falls afterwards.
- Back-to-back streaming: three words (8'hFF, 8'h00, 8'hF0, len = 7) offered with in_valid held high and enable continuous → 24 consecutive valid bits with no gap. in_ready pattern matches the hold occupancy.
- Backpressure: enable held low after the first accept → second word goes to hold and in_ready = 0; third word is held off. On enable, promotion occurs at the last bit of word 1, and in_ready rises one cycle later.
- Length clamp and single-bit word: in_len = 31 with WIDTH = 8 sends 8 bits. in_len = 0 sends exactly one bit, with last = 1 on that cycle.
- Async reset mid-word: assert reset between edges at bit 3 of a word, with hold full → sout_valid, busy and last go to 0 immediately, in_ready = 0 during reset. After release, in_ready = 1 and a new word serializes from bit 0.
